// File: rtl/clk_enable_gen_pkg.sv
// clk_enable_gen_pkg: shared lock-FSM state encoding and cfg_sel codes for clk_enable_gen
package clk_enable_gen_pkg;
  typedef enum logic {
    ST_SETTLING = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_t;
  localparam logic SEL_INC   = 1'b0;
  localparam logic SEL_PHASE = 1'b1;
endpackage

// File: rtl/clk_enable_gen_ch.sv
// clk_enable_gen_ch: one phase-accumulator channel (shadows, active regs, wrap pulse, MSB strobe); phase registers only with CLKGEN_PHASE_EN
module clk_enable_gen_ch #(
  parameter int ACC_W = 32,
  parameter int unsigned INC_RST = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_inc,
`ifdef CLKGEN_PHASE_EN
  input  logic             wr_ph,
`endif
  input  logic [ACC_W-1:0] data,
  input  logic             apply,
  output logic             ce_raw,
  output logic             sq
);
  logic [ACC_W-1:0] inc_s, inc_a, acc, sum, inc_nxt, ph_nxt;
  logic carry;
  assign inc_nxt = wr_inc ? data : inc_s;
  assign {carry, sum} = {1'b0, acc} + {1'b0, inc_a};
  assign sq = acc[ACC_W-1];
`ifdef CLKGEN_PHASE_EN
  logic [ACC_W-1:0] ph_s, ph_a;
  assign ph_nxt = wr_ph ? data : ph_s;
  // phase shadow takes writes; active phase follows it on commit
  always_ff @(posedge clk)
    if (!reset_n) begin
      ph_s <= '0;
      ph_a <= '0;
    end else begin
      ph_s <= ph_nxt;
      ph_a <= apply ? ph_nxt : ph_a;
    end
`else
  assign ph_nxt = '0;
`endif
  // accumulate every cycle; a commit reloads rate and restarts from the phase (same-cycle write included)
  always_ff @(posedge clk)
    if (!reset_n) begin
      inc_s  <= ACC_W'(INC_RST);
      inc_a  <= ACC_W'(INC_RST);
      acc    <= '0;
      ce_raw <= 1'b0;
    end else begin
      inc_s  <= inc_nxt;
      inc_a  <= apply ? inc_nxt : inc_a;
      acc    <= apply ? ph_nxt : sum;
      ce_raw <= !apply && carry;
    end
endmodule

// File: rtl/clk_enable_gen.sv
// clk_enable_gen: NUM_CH programmable-rate enable pulses and square strobes with lock indication; CLKGEN_PHASE_EN adds per-channel phase offsets
module clk_enable_gen
  import clk_enable_gen_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int ACC_W = 32,
  parameter int SETTLE_CYCLES = 16,
  parameter int unsigned INC_RST = 0,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic              cfg_sel,
  input  logic [ACC_W-1:0]  cfg_data,
  input  logic              cfg_apply,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] sq,
  output logic              locked
);
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);
  lock_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [NUM_CH-1:0] ce_raw;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic hit;
    assign hit = cfg_wr && (cfg_ch == CH_W'(g));
    clk_enable_gen_ch #(
      .ACC_W(ACC_W),
      .INC_RST(INC_RST)
    ) u_ch (
      .clk(clk),
      .reset_n(reset_n),
      .wr_inc(hit && cfg_sel == SEL_INC),
`ifdef CLKGEN_PHASE_EN
      .wr_ph(hit && cfg_sel == SEL_PHASE),
`endif
      .data(cfg_data),
      .apply(cfg_apply),
      .ce_raw(ce_raw[g]),
      .sq(sq[g])
    );
  end
  // lock state and settle counter
  always_ff @(posedge clk)
    if (!reset_n) begin
      state <= ST_SETTLING;
      cnt   <= CNT_INIT;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  // any commit restarts settling; otherwise count down to lock
  always_comb begin
    state_nxt = cfg_apply ? ST_SETTLING :
                (state == ST_SETTLING && cnt == '0) ? ST_LOCKED : state;
    cnt_nxt   = cfg_apply ? CNT_INIT :
                (state == ST_SETTLING && cnt != '0) ? cnt - 1'b1 : cnt;
  end
  // enables are suppressed until locked; strobes pass ungated
  always_comb begin
    locked = (state == ST_LOCKED);
    ce     = ce_raw & {NUM_CH{locked}};
  end
endmodule

// File: tb/tb_clk_enable_gen.sv
// tb_clk_enable_gen: directed stimulus with a per-cycle behavioural model and hand-computed spot checks
module tb_clk_enable_gen;
  localparam int NCH = 3;
  localparam int SC  = 4;
`ifdef CLKGEN_PHASE_EN
  localparam bit PH_EN = 1'b1;
`else
  localparam bit PH_EN = 1'b0;
`endif
  logic clk = 1'b0, reset_n = 1'b0, cfg_wr = 1'b0, cfg_sel = 1'b0, cfg_apply = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_data = '0;
  logic [2:0] ce, sq;
  logic locked;
  int checks = 0, errors = 0;
  bit chk_en = 1'b0;
  int m_inc_s[NCH], m_ph_s[NCH], m_inc_a[NCH], m_acc[NCH];
  bit m_wrap[NCH];
  int m_age = 0;
  int cyc = 0;

  clk_enable_gen #(
    .NUM_CH(NCH), .ACC_W(8), .SETTLE_CYCLES(SC), .INC_RST(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data), .cfg_apply(cfg_apply),
    .ce(ce), .sq(sq), .locked(locked)
  );

  always #5 clk = ~clk;

  // model: rate arithmetic modulo 256, lock = at least SC edges since the last restart
  always @(posedge clk) begin
    cyc++;
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        m_inc_s[i] = 0; m_ph_s[i] = 0; m_inc_a[i] = 0; m_acc[i] = 0; m_wrap[i] = 0;
      end
      m_age = 0;
    end else begin
      if (cfg_wr && cfg_ch < NCH) begin
        if (!cfg_sel) m_inc_s[cfg_ch] = cfg_data;
        else if (PH_EN) m_ph_s[cfg_ch] = cfg_data;
      end
      for (int i = 0; i < NCH; i++) begin
        if (cfg_apply) begin
          m_inc_a[i] = m_inc_s[i];
          m_acc[i] = m_ph_s[i];
          m_wrap[i] = 0;
        end else begin
          m_wrap[i] = (m_acc[i] + m_inc_a[i]) >= 256;
          m_acc[i] = (m_acc[i] + m_inc_a[i]) % 256;
        end
      end
      m_age = cfg_apply ? 0 : (m_age < 1000 ? m_age + 1 : m_age);
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin : cmp
    logic [2:0] e_ce, e_sq;
    logic e_lk;
    if (chk_en) begin
      e_lk = m_age >= SC;
      for (int i = 0; i < NCH; i++) begin
        e_ce[i] = m_wrap[i] && e_lk;
        e_sq[i] = m_acc[i] >= 128;
      end
      checks += 3;
      if (ce !== e_ce) begin errors++; $display("FAIL model_ce cyc %0d got %b want %b", cyc, ce, e_ce); end
      if (sq !== e_sq) begin errors++; $display("FAIL model_sq cyc %0d got %b want %b", cyc, sq, e_sq); end
      if (locked !== e_lk) begin errors++; $display("FAIL model_locked cyc %0d got %b want %b", cyc, locked, e_lk); end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] ch, input logic sel, input logic [7:0] d);
    cfg_wr = 1'b1; cfg_ch = ch; cfg_sel = sel; cfg_data = d;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  task automatic apply();
    cfg_apply = 1'b1;
    @(negedge clk);
    cfg_apply = 1'b0;
  endtask

  initial begin
    int n_ce, n_sq, first, cnt256, npulse, bad, last;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_locked", locked, 0);
    chk("rst_ce", ce, 0);
    chk("rst_sq", sq, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("s1_unlocked_e3", locked, 0);
    @(negedge clk);
    chk("s1_locked_e4", locked, 1);
    chk("s1_ce", ce, 0);
    chk("s1_sq", sq, 0);
    // single channel at 1/4 rate
    wr(0, 1'b0, 8'd64);
    apply();
    chk("s2_unlocked_a0", locked, 0);
    repeat (3) @(negedge clk);
    chk("s2_unlocked_a3", locked, 0);
    @(negedge clk);
    chk("s2_locked_a4", locked, 1);
    chk("s2_ce_a4", ce, 3'b001);
    n_ce = 0; n_sq = 0;
    repeat (16) begin
      @(negedge clk);
      n_ce += ce[0];
      n_sq += sq[0];
    end
    chk("s2_ce_count16", n_ce, 4);
    chk("s2_sq_high16", n_sq, 8);
    // phase-offset pair
    wr(0, 1'b1, 8'd0);
    wr(1, 1'b0, 8'd64);
    wr(1, 1'b1, 8'd128);
    apply();
    repeat (2) @(negedge clk);
    chk("s3_ce_a2", ce, 0);
    chk("s3_sq_a2", sq, PH_EN ? 3'b001 : 3'b011);
    repeat (2) @(negedge clk);
    chk("s3_ce_a4", ce, PH_EN ? 3'b001 : 3'b011);
    chk("s3_sq_a4", sq, PH_EN ? 3'b010 : 3'b000);
    repeat (2) @(negedge clk);
    chk("s3_ce_a6", ce, PH_EN ? 3'b010 : 3'b000);
    // non-dividing rate 3/256
    wr(2, 1'b0, 8'd3);
    apply();
    first = 0; cnt256 = 0; npulse = 0; bad = 0; last = 0;
    for (int k = 1; k <= 520; k++) begin
      @(negedge clk);
      if (ce[2]) begin
        if (first == 0) first = k;
        else if (k - last != 85 && k - last != 86) bad++;
        if (k <= 256) cnt256++;
        npulse++;
        last = k;
      end
    end
    chk("s4_first_pulse", first, 86);
    chk("s4_pulses_256", cnt256, 3);
    chk("s4_pulses_520", npulse, 6);
    chk("s4_bad_spacing", bad, 0);
    // back-to-back commits extend settling
    apply();
    n_ce = int'(ce != 0);
    chk("s5_unlocked_a1", locked, 0);
    @(negedge clk);
    n_ce += int'(ce != 0);
    apply();
    n_ce += int'(ce != 0);
    repeat (3) begin
      @(negedge clk);
      n_ce += int'(ce != 0);
    end
    chk("s5_no_ce", n_ce, 0);
    chk("s5_unlocked_b3", locked, 0);
    @(negedge clk);
    chk("s5_locked_b4", locked, 1);
    // out-of-range write with commit, then reset that overrides a same-cycle write and commit
    cfg_wr = 1'b1; cfg_ch = 2'd3; cfg_sel = 1'b0; cfg_data = 8'd99; cfg_apply = 1'b1;
    @(negedge clk);
    cfg_ch = 2'd0; cfg_data = 8'd50; reset_n = 1'b0;
    @(negedge clk);
    cfg_wr = 1'b0; cfg_apply = 1'b0; reset_n = 1'b1;
    chk("s6_rst_locked", locked, 0);
    chk("s6_rst_ce", ce, 0);
    chk("s6_rst_sq", sq, 0);
    repeat (3) @(negedge clk);
    chk("s6_unlocked_e3", locked, 0);
    @(negedge clk);
    chk("s6_locked_e4", locked, 1);
    apply();
    n_ce = 0; n_sq = 0;
    repeat (20) begin
      @(negedge clk);
      n_ce += int'(ce != 0);
      n_sq += int'(sq != 0);
    end
    chk("s6_stopped_ce", n_ce, 0);
    chk("s6_stopped_sq", n_sq, 0);
    chk("s6_relocked", locked, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
